axi_rr_arbiter: RTL and testbench

Parametrised round-robin arbiter for the shared AXI interconnect, granting one of NUM_MASTERS slave-port masters access to the downstream address and data channels. It replaces fixed two-master, address-only arbitration with fair N-way rotation, write/read direction selection, and a grant that is held until the whole transaction completes, including the write-data and read-data last beats. It sits between the per-master request lines and the channel multiplexers, which steer on grant_idx and grant_write.

---
 rtl/axi_rr_arbiter_if.sv | 31 +++
 rtl/axi_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_axi_rr_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi_rr_arbiter_if.sv
// Request and handshake bundle between the per-master request lines, the
// muxed downstream channel handshakes and the round-robin arbiter.
interface axi_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] s_awvalid;
    logic [NUM_MASTERS-1:0] s_arvalid;
    logic                   aw_hs;
    logic                   ar_hs;
    logic                   wlast_hs;
    logic                   rlast_hs;

    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic                   grant_write;

    // Request/handshake side: masters plus the downstream channel muxes.
    modport master (
        output s_awvalid, s_arvalid, aw_hs, ar_hs, wlast_hs, rlast_hs,
        input  grant, grant_idx, grant_valid, grant_write
    );

    // Arbiter side.
    modport slave (
        input  s_awvalid, s_arvalid, aw_hs, ar_hs, wlast_hs, rlast_hs,
        output grant, grant_idx, grant_valid, grant_write
    );
endinterface

// File: rtl/axi_rr_arbiter.sv
// N-way round-robin AXI arbiter: picks one master per transaction, chooses
// write or read, and holds the grant until address and last data beat complete.
module axi_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter bit WRITE_FIRST = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    axi_rr_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic                   aw_done;
    logic                   w_done;
    logic                   ar_done;

    logic [NUM_MASTERS-1:0] grant_r;
    logic [IDX_W-1:0]       grant_idx_r;
    logic                   grant_valid_r;
    logic                   grant_write_r;

    logic [NUM_MASTERS-1:0] req;
    logic                   found;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_write;
    logic [IDX_W-1:0]       next_ptr;
    int                     j;

    logic                   aw_next;
    logic                   w_next;
    logic                   ar_next;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        req       = bus.s_awvalid | bus.s_arvalid;
        found     = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && req[j]) begin
                found   = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
        win_write = bus.s_awvalid[win_idx] &&
                    (!bus.s_arvalid[win_idx] || WRITE_FIRST);
        // Wrap at NUM_MASTERS, not at 2**IDX_W, for non-power-of-two counts.
        next_ptr  = (int'(win_idx) == NUM_MASTERS - 1) ? '0 : win_idx + IDX_W'(1);
    end

    // Completion uses the flags as they will be after this edge, so a
    // handshake arriving on the same cycle as its partner still releases.
    assign aw_next = aw_done | bus.aw_hs;
    assign w_next  = w_done  | bus.wlast_hs;
    assign ar_next = ar_done | bus.ar_hs;

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            ar_done       <= 1'b0;
            grant_r       <= '0;
            grant_idx_r   <= '0;
            grant_valid_r <= 1'b0;
            grant_write_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state         <= win_write ? WRITE : READ;
                        ptr           <= next_ptr;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        ar_done       <= 1'b0;
                        grant_r       <= NUM_MASTERS'(1) << win_idx;
                        grant_idx_r   <= win_idx;
                        grant_valid_r <= 1'b1;
                        grant_write_r <= win_write;
                    end
                end

                WRITE: begin
                    if (aw_next && w_next) begin
                        state         <= IDLE;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        grant_r       <= '0;
                        grant_valid_r <= 1'b0;
                    end else begin
                        aw_done <= aw_next;
                        w_done  <= w_next;
                    end
                end

                READ: begin
                    // rlast before the address handshake is not a completion.
                    if (ar_next && bus.rlast_hs) begin
                        state         <= IDLE;
                        ar_done       <= 1'b0;
                        grant_r       <= '0;
                        grant_valid_r <= 1'b0;
                    end else begin
                        ar_done <= ar_next;
                    end
                end

                default: begin
                    state         <= IDLE;
                    grant_r       <= '0;
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_idx   = grant_idx_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_write = grant_write_r;
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: reset, rotation, direction priority,
// out-of-order write completion, grant hold and mid-transaction reset.
module tb_axi_rr_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    axi_rr_arbiter_if #(.NUM_MASTERS(4)) bus_wf ();
    axi_rr_arbiter_if #(.NUM_MASTERS(4)) bus_rf ();

    axi_rr_arbiter #(.NUM_MASTERS(4), .WRITE_FIRST(1'b1)) dut_wf (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_wf)
    );

    axi_rr_arbiter #(.NUM_MASTERS(4), .WRITE_FIRST(1'b0)) dut_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_rf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_wf.s_awvalid = '0; bus_wf.s_arvalid = '0;
        bus_wf.aw_hs = 0; bus_wf.ar_hs = 0; bus_wf.wlast_hs = 0; bus_wf.rlast_hs = 0;
        bus_rf.s_awvalid = '0; bus_rf.s_arvalid = '0;
        bus_rf.aw_hs = 0; bus_rf.ar_hs = 0; bus_rf.wlast_hs = 0; bus_rf.rlast_hs = 0;
    endtask

    int rot_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_inputs();
        reset_n = 1'b0;

        // Reset with every master requesting a write.
        bus_wf.s_awvalid = 4'b1111;
        tick(); tick();
        check("rst_grant", 32'(bus_wf.grant), 32'h0);
        check("rst_valid", 32'(bus_wf.grant_valid), 32'h0);
        check("rst_idx", 32'(bus_wf.grant_idx), 32'h0);
        check("rst_write", 32'(bus_wf.grant_write), 32'h0);
        reset_n = 1'b1;
        tick();
        check("first_grant", 32'(bus_wf.grant), 32'h1);
        check("first_valid", 32'(bus_wf.grant_valid), 32'h1);
        check("first_write", 32'(bus_wf.grant_write), 32'h1);
        bus_wf.s_awvalid = '0; bus_wf.aw_hs = 1; bus_wf.wlast_hs = 1;
        tick();
        check("first_release", 32'(bus_wf.grant_valid), 32'h0);
        check("first_rel_grant", 32'(bus_wf.grant), 32'h0);
        check("first_hold_write", 32'(bus_wf.grant_write), 32'h1);
        clear_inputs();

        // Rotation across all four readers, pointer wraps 3 -> 0.
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        bus_wf.s_arvalid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rot%0d_idx", i), 32'(bus_wf.grant_idx), 32'(rot_exp[i]));
            check($sformatf("rot%0d_grant", i), 32'(bus_wf.grant), 32'd1 << rot_exp[i]);
            check($sformatf("rot%0d_write", i), 32'(bus_wf.grant_write), 32'h0);
            bus_wf.ar_hs = 1;
            tick();
            check($sformatf("rot%0d_hold", i), 32'(bus_wf.grant_valid), 32'h1);
            bus_wf.ar_hs = 0; bus_wf.rlast_hs = 1;
            tick();
            check($sformatf("rot%0d_rel", i), 32'(bus_wf.grant_valid), 32'h0);
            bus_wf.rlast_hs = 0;
        end
        bus_wf.s_arvalid = '0;
        tick();
        check("rot_idle", 32'(bus_wf.grant_valid), 32'h0);

        // Direction priority: master 2 requests both (wf ptr=1, rf ptr=0).
        bus_wf.s_awvalid = 4'b0100; bus_wf.s_arvalid = 4'b0100;
        bus_rf.s_awvalid = 4'b0100; bus_rf.s_arvalid = 4'b0100;
        tick();
        check("dir_wf_idx", 32'(bus_wf.grant_idx), 32'h2);
        check("dir_wf_write", 32'(bus_wf.grant_write), 32'h1);
        check("dir_rf_idx", 32'(bus_rf.grant_idx), 32'h2);
        check("dir_rf_write", 32'(bus_rf.grant_write), 32'h0);
        clear_inputs();
        bus_wf.aw_hs = 1; bus_wf.wlast_hs = 1;
        bus_rf.ar_hs = 1; bus_rf.rlast_hs = 1;
        tick();
        check("dir_wf_rel", 32'(bus_wf.grant_valid), 32'h0);
        check("dir_rf_rel", 32'(bus_rf.grant_valid), 32'h0);
        clear_inputs();

        // W before AW on master 1 (ptr=3, search 3,0,1).
        bus_wf.s_awvalid = 4'b0010;
        tick();
        check("wfirst_idx", 32'(bus_wf.grant_idx), 32'h1);
        check("wfirst_write", 32'(bus_wf.grant_write), 32'h1);
        bus_wf.wlast_hs = 1;
        tick();
        check("wfirst_c1", 32'(bus_wf.grant_valid), 32'h1);
        bus_wf.wlast_hs = 0;
        tick();
        check("wfirst_c2", 32'(bus_wf.grant_valid), 32'h1);
        bus_wf.aw_hs = 1;
        tick();
        check("wfirst_c4", 32'(bus_wf.grant_valid), 32'h0);
        bus_wf.aw_hs = 0; bus_wf.s_awvalid = '0;

        // Hold: master 0 reading (ptr=2, search 2,3,0), master 3 waits.
        bus_wf.s_arvalid = 4'b0001;
        tick();
        check("hold_grant0", 32'(bus_wf.grant), 32'h1);
        bus_wf.rlast_hs = 1; bus_wf.s_awvalid = 4'b1000;
        tick();
        check("hold_early_rlast", 32'(bus_wf.grant), 32'h1);
        bus_wf.rlast_hs = 0;
        tick();
        check("hold_wait", 32'(bus_wf.grant), 32'h1);
        bus_wf.ar_hs = 1;
        tick();
        check("hold_after_ar", 32'(bus_wf.grant), 32'h1);
        bus_wf.ar_hs = 0; bus_wf.s_arvalid = '0; bus_wf.rlast_hs = 1;
        tick();
        check("hold_release", 32'(bus_wf.grant), 32'h0);
        bus_wf.rlast_hs = 0;
        tick();
        check("hold_next_grant", 32'(bus_wf.grant), 32'h8);
        check("hold_next_write", 32'(bus_wf.grant_write), 32'h1);
        bus_wf.s_awvalid = '0; bus_wf.aw_hs = 1; bus_wf.wlast_hs = 1;
        tick();
        check("hold_m3_rel", 32'(bus_wf.grant_valid), 32'h0);
        clear_inputs();

        // Mid-transaction reset: master 2 writing with aw_done set (ptr=0).
        bus_wf.s_awvalid = 4'b0100;
        tick();
        check("mid_idx", 32'(bus_wf.grant_idx), 32'h2);
        bus_wf.aw_hs = 1;
        tick();
        check("mid_held", 32'(bus_wf.grant_valid), 32'h1);
        bus_wf.aw_hs = 0; reset_n = 1'b0;
        tick();
        check("mid_rst_grant", 32'(bus_wf.grant), 32'h0);
        check("mid_rst_valid", 32'(bus_wf.grant_valid), 32'h0);
        check("mid_rst_idx", 32'(bus_wf.grant_idx), 32'h0);
        check("mid_rst_write", 32'(bus_wf.grant_write), 32'h0);
        reset_n = 1'b1; bus_wf.s_awvalid = '0; bus_wf.s_arvalid = 4'b0010;
        tick();
        check("mid_after_idx", 32'(bus_wf.grant_idx), 32'h1);
        check("mid_after_grant", 32'(bus_wf.grant), 32'h2);

        // Coincident ar_hs and rlast_hs releases in one cycle.
        bus_wf.s_arvalid = '0; bus_wf.ar_hs = 1; bus_wf.rlast_hs = 1;
        tick();
        check("coinc_rel", 32'(bus_wf.grant_valid), 32'h0);
        check("coinc_hold_idx", 32'(bus_wf.grant_idx), 32'h1);
        clear_inputs();

        // Pointer is 2: masters 0 and 3 request, 3 wins.
        bus_wf.s_arvalid = 4'b1001;
        tick();
        check("ptr_idx", 32'(bus_wf.grant_idx), 32'h3);
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
